// File: rtl/lane_terrain_engine.sv
// Scrolling multi-lane terrain generator: per-lane LFSR columns shifted toward
// column 0 at a prescaled rate, with gap limiting and a guaranteed solid lane.
module lane_terrain_engine #(
  parameter int          LANES   = 3,
  parameter int          WIDTH   = 640,
  parameter int          PROBE   = 20,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          MAX_GAP = 8,
  parameter int          DIV_W   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       speed,
  output logic [LANES*WIDTH-1:0] ground,
  output logic [LANES-1:0]       probe,
  output logic                   step,
  output logic [15:0]            scroll_count
);

  localparam int         RR_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0] GAP_LIM = 8'(MAX_GAP);
  localparam logic [RR_W-1:0] RR_LAST = RR_W'(LANES - 1);

  logic [LANES*WIDTH-1:0] r_ground;
  logic [DIV_W-1:0]       r_div_cnt;
  logic [15:0]            r_lfsr [LANES];
  logic [7:0]             r_gap  [LANES];
  logic [RR_W-1:0]        r_rr;
  logic                   r_step;
  logic [15:0]            r_scroll_count;

  logic                   w_hit;
  logic [LANES-1:0]       w_cand;
  logic [LANES-1:0]       w_new;
  logic [15:0]            w_lfsr_next [LANES];

  // A zero seed would lock the LFSR, so it is nudged to 1.
  function automatic logic [15:0] seedOf(input int l);
    logic [15:0] s;
    s = SEED ^ 16'(l * 16'h1F35);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  always_comb begin
    w_hit = enable && ((speed <= DIV_W'(1)) || (r_div_cnt >= speed - DIV_W'(1)));
    w_cand = '0;
    for (int l = 0; l < LANES; l++) begin
      w_cand[l]      = r_lfsr[l][0] | (r_gap[l] == GAP_LIM);
      w_lfsr_next[l] = {1'b0, r_lfsr[l][15:1]} ^ (r_lfsr[l][0] ? 16'hB400 : 16'h0000);
    end
    w_new = w_cand;
    // An all-empty column is never inserted; the round-robin lane takes the solid bit.
    if (w_cand == '0) w_new[r_rr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt      <= '0;
      r_step         <= 1'b0;
      r_scroll_count <= 16'h0000;
      r_rr           <= '0;
      r_ground       <= '1;
      for (int l = 0; l < LANES; l++) begin
        r_lfsr[l] <= seedOf(l);
        r_gap[l]  <= 8'h00;
      end
    end else begin
      r_step <= w_hit;
      if (enable) r_div_cnt <= w_hit ? '0 : r_div_cnt + DIV_W'(1);
      if (w_hit) begin
        r_scroll_count <= r_scroll_count + 16'h0001;
        r_rr           <= (r_rr == RR_LAST) ? '0 : r_rr + RR_W'(1);
        for (int l = 0; l < LANES; l++) begin
          r_lfsr[l] <= w_lfsr_next[l];
          r_gap[l]  <= w_new[l] ? 8'h00 : r_gap[l] + 8'h01;
          r_ground[l*WIDTH +: WIDTH] <= {w_new[l], r_ground[l*WIDTH+1 +: WIDTH-1]};
        end
      end
    end
  end

  always_comb begin
    probe = '0;
    for (int l = 0; l < LANES; l++) probe[l] = r_ground[l*WIDTH+PROBE];
  end

  assign ground       = r_ground;
  assign step         = r_step;
  assign scroll_count = r_scroll_count;

endmodule

// File: tb/tb_lane_terrain_engine.sv
// Directed bench for lane_terrain_engine: default instance plus a LANES=1,
// MAX_GAP=1 instance sharing clock and controls.
module tb_lane_terrain_engine;

  localparam int LANES = 3;
  localparam int WIDTH = 640;
  localparam int MAXG  = 8;

  logic                   clk;
  logic                   reset;
  logic                   enable;
  logic [19:0]            speed;
  logic [LANES*WIDTH-1:0] ground;
  logic [LANES-1:0]       probe;
  logic                   step;
  logic [15:0]            scroll_count;

  logic [15:0]            ground1;
  logic [0:0]             probe1;
  logic                   step1;
  logic [15:0]            count1;

  int assertCount = 0;
  int failCount   = 0;

  logic [LANES*WIDTH-1:0] gSaved;
  int                     gap [LANES];
  logic [LANES-1:0]       col;
  logic [14:0]            adj;

  lane_terrain_engine dut (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed),
    .ground(ground), .probe(probe), .step(step), .scroll_count(scroll_count)
  );

  lane_terrain_engine #(.LANES(1), .WIDTH(16), .PROBE(3), .MAX_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed),
    .ground(ground1), .probe(probe1), .step(step1), .scroll_count(count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [19:0] spd);
    enable = en;
    speed  = spd;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 20'd0);
    repeat (3) tick();
    checkOutput("rst_ground", 64'(ground === '1), 64'd1);
    checkOutput("rst_probe", 64'(probe), 64'h7);
    checkOutput("rst_step", 64'(step), 64'd0);
    checkOutput("rst_count", 64'(scroll_count), 64'd0);
    checkOutput("rst_ground1", 64'(ground1), 64'hFFFF);

    // enable low: nothing moves
    reset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      checkOutput("idle_step", 64'(step), 64'd0);
    end
    checkOutput("idle_ground", 64'(ground === '1), 64'd1);
    checkOutput("idle_probe", 64'(probe), 64'h7);
    checkOutput("idle_count", 64'(scroll_count), 64'd0);

    // first five inserted columns, hand-derived from the seeds
    applyStimulus(1'b1, 20'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("spd1_step", 64'(step), 64'd1);
    end
    checkOutput("spd1_count", 64'(scroll_count), 64'd5);
    checkOutput("lane0_top5", 64'(ground[0*WIDTH+WIDTH-5 +: 5]), 64'b00001);
    checkOutput("lane1_top5", 64'(ground[1*WIDTH+WIDTH-5 +: 5]), 64'b10100);
    checkOutput("lane2_top5", 64'(ground[2*WIDTH+WIDTH-5 +: 5]), 64'b01011);
    checkOutput("lane0_rest", 64'(ground[0*WIDTH +: WIDTH-5] === '1), 64'd1);
    checkOutput("spd1_probe", 64'(probe), 64'h7);

    // speed 4: step every 4th enabled cycle, lanes shift by 25
    applyStimulus(1'b1, 20'd4);
    gSaved = ground;
    for (int k = 1; k <= 100; k++) begin
      tick();
      checkOutput("spd4_step", 64'(step), 64'((k % 4) == 0));
    end
    checkOutput("spd4_count", 64'(scroll_count), 64'd30);
    for (int l = 0; l < LANES; l++)
      checkOutput("spd4_shift",
                  64'(ground[l*WIDTH +: WIDTH-25] === gSaved[l*WIDTH+25 +: WIDTH-25]), 64'd1);

    // enable pause holds the prescaler mid-count
    tick(); tick();
    applyStimulus(1'b0, 20'd4);
    repeat (10) tick();
    checkOutput("pause_step", 64'(step), 64'd0);
    applyStimulus(1'b1, 20'd4);
    tick();
    checkOutput("resume_1", 64'(step), 64'd0);
    tick();
    checkOutput("resume_2", 64'(step), 64'd1);
    checkOutput("resume_count", 64'(scroll_count), 64'd31);

    // reset mid-count discards the partial interval
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_count", 64'(scroll_count), 64'd0);
    checkOutput("midrst_ground", 64'(ground === '1), 64'd1);
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("midrst_step", 64'(step), 64'(k == 4));
    end

    // determinism across reset: 37 steps twice
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 20'd0);
    reset = 1'b1;
    repeat (37) tick();
    gSaved = ground;
    checkOutput("run1_count", 64'(scroll_count), 64'd37);
    repeat (20) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (37) tick();
    checkOutput("run2_count", 64'(scroll_count), 64'd37);
    checkOutput("run2_match", 64'(ground === gSaved), 64'd1);

    // lowering speed below div_cnt steps at once
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 20'd1000);
    reset = 1'b1;
    repeat (500) tick();
    checkOutput("slow_count", 64'(scroll_count), 64'd0);
    applyStimulus(1'b1, 20'd100);
    tick();
    checkOutput("lower_step", 64'(step), 64'd1);
    repeat (99) tick();
    checkOutput("lower_wait", 64'(scroll_count), 64'd1);
    tick();
    checkOutput("lower_step2", 64'(step), 64'd1);
    checkOutput("lower_count", 64'(scroll_count), 64'd2);

    // long run: gap limit, solid column, single-lane instance never has adjacent zeros
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 20'd0);
    reset = 1'b1;
    for (int l = 0; l < LANES; l++) gap[l] = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      for (int l = 0; l < LANES; l++) begin
        col[l] = ground[l*WIDTH+WIDTH-1];
        gap[l] = col[l] ? 0 : gap[l] + 1;
        checkOutput("gap_limit", 64'(gap[l] > MAXG), 64'd0);
      end
      checkOutput("col_solid", 64'(col != '0), 64'd1);
      adj = ~ground1[14:0] & ~ground1[15:1];
      checkOutput("lane1_adj", 64'(adj), 64'd0);
    end
    checkOutput("long_count", 64'(scroll_count), 64'd2000);
    checkOutput("long_count1", 64'(count1), 64'd2000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/lane_terrain_engine.md
LANE_TERRAIN_ENGINE -- requirements
Module: lane_terrain_engine

Interface
REQ-001 SHALL have parameter LANES, default 3: number of ground lanes (1..8).
REQ-002 SHALL have parameter WIDTH, default 640: columns per lane.
REQ-003 SHALL have parameter PROBE, default 20: column index sampled for collision (0..WIDTH-1).
REQ-004 SHALL have parameter SEED, default 16'hACE1: base LFSR seed.
REQ-005 SHALL have parameter MAX_GAP, default 8: maximum consecutive empty columns per lane (1..255).
REQ-006 SHALL have parameter DIV_W, default 20: prescaler width.
REQ-007 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1: scrolling permitted while high.
REQ-010 SHALL have port speed, input, DIV_W: enabled cycles per scroll step.
REQ-011 SHALL have port ground, output, LANES*WIDTH: lane l occupies bits [l*WIDTH +: WIDTH]; 1 = solid.
REQ-012 SHALL have port probe, output, LANES: bit l = ground[l*WIDTH+PROBE], combinational from the register.
REQ-013 SHALL have port step, output, 1: one-cycle pulse on the cycle the lanes shift.
REQ-014 SHALL have port scroll_count, output, 16: steps taken since reset, wraps 16'hFFFF -> 0.

Function
REQ-015 SHALL hold prescaler div_cnt (DIV_W bits), incrementing only on cycles with enable=1.
REQ-016 SHALL assert step and clear div_cnt on an enabled cycle where div_cnt >= speed-1; speed 0 or 1 SHALL step every enabled cycle.
REQ-017 SHALL hold div_cnt and all lane state, and keep step=0, while enable=0; counting resumes from the held value.
REQ-018 SHALL, when speed is lowered below the current div_cnt, step on the next enabled cycle (no wrap-around wait).
REQ-019 SHALL, on step, shift every lane toward column 0 (col i <= col i+1) and load column WIDTH-1 with that lane's new bit; column 0 is discarded.
REQ-020 SHALL give each lane a 16-bit Galois LFSR (mask 16'hB400, right shift, feedback from bit 0), seeded SEED ^ (l * 16'h1F35), seed 16'h0000 replaced by 16'h0001.
REQ-021 SHALL advance each LFSR exactly once per step and never otherwise; candidate bit = LFSR bit 0 before advance.
REQ-022 SHALL keep an 8-bit gap counter per lane: increments on inserting 0, clears on inserting 1.
REQ-023 SHALL force the new bit of a lane to 1 when its gap counter equals MAX_GAP.
REQ-024 SHALL keep a round-robin pointer rr (0..LANES-1), advancing by one per step and wrapping LANES-1 -> 0.
REQ-025 SHALL, when all lanes' new bits (after REQ-023) would be 0, force lane rr's new bit to 1, so every inserted column has at least one solid lane.
REQ-026 SHALL increment scroll_count by one on each step.
REQ-027 SHALL register all outputs except probe; step, ground and scroll_count update on the same edge.

Reset
REQ-028 SHALL, while reset=0, immediately set ground to all ones, step=0, scroll_count=0, div_cnt=0, gap counters=0, rr=0, LFSRs to seeds.
REQ-029 SHALL abandon any in-progress prescaler count on reset mid-operation; the first step after release needs a full speed interval.
REQ-030 SHALL produce an identical ground sequence after every reset for identical enable/speed stimulus.

Verification
REQ-031 Reset release, enable=0 for 100 cycles -> ground all ones, probe=3'b111, step never high, scroll_count=0.
REQ-032 speed=4, enable=1 -> step pulses on every 4th cycle, scroll_count=25 after 100 enabled cycles, ground shifted by 25.
REQ-033 speed=0, enable=1 for 2000 cycles -> no lane has more than MAX_GAP consecutive zeros; every column has at least one 1.
REQ-034 LANES=1, MAX_GAP=1 -> no two adjacent zeros ever appear in ground.
REQ-035 speed=1000, div_cnt=500, speed changed to 100 -> step on next enabled cycle, then every 100.
REQ-036 Assert reset mid-run after 37 steps, release, rerun -> first 37 inserted columns match the first run bit-for-bit.
